// File: rtl/csr_port_arbiter_pkg.sv
// Shared types and constants for the CSR port arbiter and its 2-way grant picker.
// Holds the FSM encoding, the read-only CSR prefix and a few well-known CSR addresses.
package csr_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic [1:0]  CSR_RO_PREFIX = 2'b11;

  localparam logic [11:0] MCYCLE    = 12'hB00;
  localparam logic [11:0] MCYCLEH   = 12'hB80;
  localparam logic [11:0] MVENDORID = 12'hF11;
  localparam logic [11:0] MARCHID   = 12'hF12;

endpackage

// File: rtl/csr_rr_pick.sv
// 2-way grant picker: one-hot grant, round-robin on ties (or port 0 in fixed mode).
// Latency: purely combinational; no backpressure, the caller qualifies the grant.
module csr_rr_pick
  import csr_port_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       rr_mode,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie: the port that did not win last time goes next.
      2'b11:   grant = (rr_mode && !last_grant) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/csr_port_arbiter.sv
// Serializes two requesters onto one CSR file port (IDLE -> ACCESS -> RESP); optional CSR_ARB_RO_CHECK_EN.
// Latency: accept N, CSR access N+1, response from N+2; no accept outside IDLE, response held until resp_ready.
module csr_port_arbiter
  import csr_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter bit RR_EN_INIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_wen,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                csr_wen,
  output logic [ADDR_W-1:0]   csr_addr,
  output logic [DATA_W-1:0]   csr_wdata,
  input  logic [DATA_W-1:0]   csr_rdata,
  output logic                busy
);

  arb_state_t          state, state_nx;
  logic [1:0]          grant;
  logic                hs;
  logic                sel;
  logic                rr_mode;
  logic                owner;
  logic                last_grant;
  logic                cap_wen;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic                ro_hit;

  assign rr_mode = RR_EN_INIT;

  csr_rr_pick u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .rr_mode    (rr_mode),
    .grant      (grant)
  );

  assign hs  = |(req_valid & req_ready);
  assign sel = req_ready[1];

`ifdef CSR_ARB_RO_CHECK_EN
  logic err_q;

  // Writes into the read-only CSR space are dropped and flagged.
  assign ro_hit   = cap_wen && (cap_addr[ADDR_W-1 -: 2] == CSR_RO_PREFIX);
  assign resp_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 err_q <= 1'b0;
    else if (state == ACCESS) err_q <= ro_hit;
  end
`else
  assign ro_hit   = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    csr_wen    = 1'b0;
    csr_addr   = '0;
    csr_wdata  = '0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = grant;
        if (hs) state_nx = ACCESS;
      end
      ACCESS: begin
        // The CSR port is only driven here so the file never sees a stray write.
        csr_wen   = cap_wen && !ro_hit;
        csr_addr  = cap_addr;
        csr_wdata = cap_wdata;
        state_nx  = RESP;
      end
      RESP: begin
        resp_valid = owner ? 2'b10 : 2'b01;
        if (resp_ready[owner]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cap_wen    <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rdata_q    <= '0;
    end else begin
      if (hs) begin
        owner      <= sel;
        last_grant <= sel;
        cap_wen    <= req_wen[sel];
        cap_addr   <= sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        cap_wdata  <= sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      end
      // Sampled before the write lands: the requester sees the old value.
      if (state == ACCESS) rdata_q <= csr_rdata;
    end
  end

  assign resp_rdata = rdata_q;

endmodule
